// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared encodings for the data-memory bus controller and the load-extend path.
package dmem_bus_ctrl_pkg;
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic is_misal(input logic [1:0] size, input logic [1:0] alo);
    return (size == SIZE_WORD && alo != 2'b00) || (size == SIZE_HALF && alo[0]);
  endfunction
endpackage

// File: rtl/dmem_bus_ctrl_load_extend.sv
// Right-justified load data extension; size 2'b11 falls through to byte.
module load_extend
  import dmem_bus_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic [1:0]           size,
  input  logic                 sgn,
  input  logic [BIT_WIDTH-1:0] raw,
  output logic [BIT_WIDTH-1:0] data
);
  always_comb begin
    data = raw;
    case (size)
      SIZE_WORD: data = raw;
      SIZE_HALF: data = {{(BIT_WIDTH-16){sgn & raw[15]}}, raw[15:0]};
      default:   data = {{(BIT_WIDTH-8){sgn & raw[7]}}, raw[7:0]};
    endcase
  end
endmodule

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage data bus sequencer: one bus cycle per request, stall until ack,
// misalignment rejection and bounded wait for ACKD_n.
module dmem_bus_ctrl
  import dmem_bus_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 stall,
  output logic                 rsp_valid,
  output logic [BIT_WIDTH-1:0] rsp_rdata,
  output logic                 err_misal,
  output logic                 err_tmo,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  input  logic                 ACKD_n
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_WIDTH-1:0] wdata_q;
  logic                 sgn_q;
  logic [BIT_WIDTH-1:0] st_data;
  logic [BIT_WIDTH-1:0] ld_data;

  // Store data is lane-formatted at latch time so DDT is a plain register.
  always_comb begin
    st_data = req_wdata;
    case (req_size)
      SIZE_WORD: st_data = req_wdata;
      SIZE_HALF: st_data = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
      default:   st_data = {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
    endcase
  end

  assign DDT   = (MREQ && WRITE) ? wdata_q : {BIT_WIDTH{1'bz}};
  assign stall = req_valid & ~rsp_valid;

  load_extend #(.BIT_WIDTH(BIT_WIDTH)) u_ext (
    .size (SIZE),
    .sgn  (sgn_q),
    .raw  (DDT),
    .data (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      MREQ      <= 1'b0;
      WRITE     <= 1'b0;
      DAD       <= '0;
      SIZE      <= SIZE_WORD;
      wdata_q   <= '0;
      sgn_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      err_misal <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      err_misal <= 1'b0;
      err_tmo   <= 1'b0;
      case (state)
        ST_IDLE: if (req_valid) begin
          rsp_rdata <= '0;
          if (is_misal(req_size, req_addr[1:0])) begin
            err_misal <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            DAD     <= req_addr;
            SIZE    <= req_size;
            WRITE   <= req_write;
            wdata_q <= st_data;
            sgn_q   <= req_signed;
            MREQ    <= 1'b1;
            cnt     <= '0;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: if (!ACKD_n) begin
          MREQ      <= 1'b0;
          WRITE     <= 1'b0;
          if (!WRITE) rsp_rdata <= ld_data;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end else begin
          cnt <= cnt + 1'b1;
          // Ack on the final allowed cycle still wins over the timeout.
          if (TMO_EN && cnt == TMO_LAST) begin
            MREQ      <= 1'b0;
            WRITE     <= 1'b0;
            err_tmo   <= 1'b1;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
